// File: rtl/dbus_sram_slave.sv
// Data-bus slave SRAM with programmable wait states and a windowed interrupt.
// Define DBUS_TRACE_EN to register a one-cycle write trace for the checker.
module dbus_sram_slave #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned INT_START   = 40,
   parameter int unsigned INT_END     = 45
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_read,
   input  logic        bus_write,
   input  logic [31:0] bus_address,
   input  logic [3:0]  bus_mask,
   input  logic [31:0] bus_wrdata,
   output logic [31:0] bus_rddata,
   output logic        bus_stall,
   output logic [5:0]  interrupt,
   output logic        trace_we,
   output logic [15:0] trace_addr,
   output logic [31:0] trace_data
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;
   localparam logic [3:0] WC      = 4'(WAIT_CYCLES);

   logic [31:0]       mem [2**ADDR_W];
   logic [0:0]        state;
   logic [3:0]        cnt;
   logic [15:0]       cnt_cyc;
   logic              req;
   logic              done;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       old_word;
   logic [31:0]       merged;
   logic [31:0]       cyc_w;
   logic              int_hit;

   assign req      = bus_read | bus_write;
   assign idx      = bus_address[ADDR_W+1:2];
   assign old_word = mem[idx];

   // Reset gates completion so an access caught by reset never writes.
   always_comb begin
      done = 1'b0;
      if (rst_n && req) begin
         if (state == ST_IDLE)
            done = (WC == 4'd0);
         else
            done = (cnt == WC);
      end
   end

   assign bus_stall  = rst_n & req & ~done;
   assign bus_rddata = (done && bus_read) ? old_word : 32'd0;

   always_comb begin
      merged = old_word;
      for (int b = 0; b < 4; b++)
         if (bus_mask[b])
            merged[8*b +: 8] = bus_wrdata[8*b +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else if (state == ST_IDLE) begin
         if (req && WC != 4'd0) begin
            state <= ST_WAIT;
            cnt   <= 4'd1;
         end
      end else begin
         if (!req || cnt == WC) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (done && bus_write)
         mem[idx] <= merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_cyc <= 16'd0;
      else if (cnt_cyc != 16'hFFFF)
         cnt_cyc <= cnt_cyc + 16'd1;
   end

   assign cyc_w     = {16'd0, cnt_cyc};
   assign int_hit   = (cyc_w >= INT_START) && (cyc_w <= INT_END);
   assign interrupt = {5'd0, int_hit};

`ifdef DBUS_TRACE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trace_we   <= 1'b0;
         trace_addr <= 16'd0;
         trace_data <= 32'd0;
      end else begin
         trace_we <= done & bus_write;
         if (done && bus_write) begin
            trace_addr <= {bus_address[15:2], 2'b00};
            trace_data <= merged;
         end
      end
   end
`else
   assign trace_we   = 1'b0;
   assign trace_addr = 16'd0;
   assign trace_data = 32'd0;
`endif

   logic unused_addr;
   assign unused_addr = ^{bus_address[31:ADDR_W+2], bus_address[1:0]};

endmodule

// File: tb/tb_dbus_sram_slave.sv
// Randomized bench for dbus_sram_slave: a zero-wait and a three-wait
// instance checked against word-array models of the memory.
module tb_dbus_sram_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd0 = 1'b0, wr0 = 1'b0, rd3 = 1'b0, wr3 = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  mask = '0;
   logic [31:0] rdat0, rdat3, td0, td3;
   logic        stall0, stall3, tw0, tw3;
   logic [5:0]  int0, int3;
   logic [15:0] ta0, ta3;

   int checks = 0;
   int failures = 0;

   logic [31:0] ref0 [int];
   logic [31:0] ref3 [int];

   always #5 clk = ~clk;

   dbus_sram_slave #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus_read(rd0), .bus_write(wr0),
      .bus_address(addr), .bus_mask(mask), .bus_wrdata(wdata),
      .bus_rddata(rdat0), .bus_stall(stall0), .interrupt(int0),
      .trace_we(tw0), .trace_addr(ta0), .trace_data(td0));

   dbus_sram_slave #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus_read(rd3), .bus_write(wr3),
      .bus_address(addr), .bus_mask(mask), .bus_wrdata(wdata),
      .bus_rddata(rdat3), .bus_stall(stall3), .interrupt(int3),
      .trace_we(tw3), .trace_addr(ta3), .trace_data(td3));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One full access started on a negedge; ends on a negedge with the bus idle.
   task automatic access(input bit s3, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d);
      int          idx;
      int          w;
      logic [31:0] old, nw;
      idx = int'((a >> 2) & 32'd1023);
      w   = s3 ? 3 : 0;
      old = 32'd0;
      if (s3 && ref3.exists(idx)) old = ref3[idx];
      if (!s3 && ref0.exists(idx)) old = ref0[idx];
      nw = old;
      for (int b = 0; b < 4; b++)
         if (m[b]) nw[8*b +: 8] = d[8*b +: 8];
      addr = a; mask = m; wdata = d;
      if (s3) begin rd3 = rd; wr3 = wr; end
      else begin rd0 = rd; wr0 = wr; end
      for (int k = 0; k <= w; k++) begin
         #1;
         chk("stall", s3 ? stall3 : stall0, (k < w) ? 32'd1 : 32'd0);
         if (k == w)
            chk("rddata", s3 ? rdat3 : rdat0, rd ? old : 32'd0);
         @(negedge clk);
      end
      if (wr) begin
         if (s3) ref3[idx] = nw;
         else ref0[idx] = nw;
      end
      rd0 = 0; wr0 = 0; rd3 = 0; wr3 = 0;
      #1;
`ifdef DBUS_TRACE_EN
      chk("trace_we", s3 ? tw3 : tw0, wr ? 32'd1 : 32'd0);
      if (wr) begin
         chk("trace_addr", s3 ? ta3 : ta0, {16'd0, a[15:2], 2'b00});
         chk("trace_data", s3 ? td3 : td0, nw);
      end
`else
      chk("trace_we", s3 ? tw3 : tw0, 32'd0);
`endif
      chk("idle_stall", s3 ? stall3 : stall0, 32'd0);
      @(negedge clk);
      #1;
      chk("trace_pulse", s3 ? tw3 : tw0, 32'd0);
      @(negedge clk);
   endtask

   task automatic rand_access(input bit s3);
      logic [31:0] a;
      bit          rd, wr;
      a  = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 12)
           | $urandom_range(0, 3);
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      access(s3, rd, wr, a, 4'($urandom), $urandom);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall0", stall0, 32'd0);
      chk("rst_rdata0", rdat0, 32'd0);
      chk("rst_int0", int0, 32'd0);
      chk("rst_tw0", tw0, 32'd0);
      chk("rst_td0", td0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         access(0, 0, 1, i * 4, 4'hF, $urandom);
         access(1, 0, 1, i * 4, 4'hF, $urandom);
      end

      access(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
      access(0, 1, 0, 32'h10, 4'h0, 32'h0);
      chk("t1_word", ref0[4], 32'hDEADBEEF);
      access(1, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
      access(1, 1, 0, 32'h10, 4'h0, 32'h0);

      access(0, 0, 1, 32'h10, 4'hF, 32'h11223344);
      access(0, 0, 1, 32'h10, 4'b0101, 32'hAABBCCDD);
      access(0, 1, 0, 32'h10, 4'h0, 32'h0);
      chk("t3_merge", ref0[4], 32'h11BB33DD);
      access(0, 0, 1, 32'h14, 4'h0, 32'hFFFFFFFF);
      access(0, 1, 1, 32'h14, 4'hF, 32'h01020304);
      access(0, 1, 0, 32'h14, 4'h0, 32'h0);

      access(0, 0, 1, 32'h1000, 4'hF, 32'h5);
      access(0, 1, 0, 32'h0000, 4'h0, 32'h0);
      chk("t4_wrap", ref0[0], 32'h5);

      for (int i = 0; i < 40; i++) begin
         rand_access(0);
         rand_access(1);
      end

      addr = 32'h20; mask = 4'hF; wdata = 32'hFFFFFFFF; wr3 = 1'b1;
      #1;
      chk("t5_stall_T", stall3, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_stall_rst", stall3, 32'd0);
      chk("t5_rdata_rst", rdat3, 32'd0);
      @(negedge clk);
      wr3 = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      access(1, 1, 0, 32'h20, 4'h0, 32'h0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("int0_c%0d", k), int0,
             (k >= 40 && k <= 45) ? 32'd1 : 32'd0);
         chk($sformatf("int3_c%0d", k), int3,
             (k >= 40 && k <= 45) ? 32'd1 : 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
